button_conditioner: RTL and testbench

Input-conditioning stage between the raw direction buttons and the game logic / welcome-screen control. It synchronises and debounces the four push-buttons, turns debounced presses into single move commands, and arbitrates simultaneous presses. Each command is held in a one-entry buffer until the consumer accepts it with a valid/ready handshake. The consumer is the frame-rate grid update.

---
 rtl/button_conditioner.sv | 180 ++++++++++++++++++
 tb/tb_button_conditioner.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/button_conditioner.sv
// Synchronises, debounces and arbitrates four direction buttons into buffered move commands.
// Optional auto-repeat while a button is held is enabled by defining BTN_AUTOREPEAT_EN.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES     = 50000,
  parameter int REPEAT_DELAY_FRAMES = 30,
  parameter int REPEAT_RATE_FRAMES  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  input  logic       frame_tick,
  input  logic       move_ready,
  output logic       move_valid,
  output logic [1:0] move_dir,
  output logic [3:0] btn_stable,
  output logic       any_pressed
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  // Fixed priority up > down > left > right.
  function automatic logic [1:0] pick_dir(input logic [3:0] evt);
    if (evt[0]) begin
      return 2'd0;
    end else if (evt[1]) begin
      return 2'd1;
    end else if (evt[2]) begin
      return 2'd2;
    end else begin
      return 2'd3;
    end
  endfunction

  logic [3:0]    sync1_r, sync2_r, stable_r, stable_prev_r;
  logic [CW-1:0] db_cnt_r [4];
  logic [3:0]    press_s, held_mask_s, evt_s;
  logic          take_s, move_valid_r, valid_s;
  logic [1:0]    move_dir_r, dir_s;
  state_t        state_r, state_s, mid_s;

`ifdef BTN_AUTOREPEAT_EN
  localparam int RMAX0 = (REPEAT_DELAY_FRAMES > REPEAT_RATE_FRAMES) ? REPEAT_DELAY_FRAMES : REPEAT_RATE_FRAMES;
  localparam int RMAX  = (RMAX0 > 1) ? RMAX0 : 1;
  localparam int RW    = $clog2(RMAX + 1);
  logic [RW-1:0] rep_cnt_r, rep_cnt_s;
  logic          rep_flag_r, rep_flag_s;
`else
  logic unused_s;
  assign unused_s = ^{frame_tick, 32'(REPEAT_DELAY_FRAMES), 32'(REPEAT_RATE_FRAMES)};
`endif

  // Two-flop synchroniser for the asynchronous button inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_r <= 4'd0;
      sync2_r <= 4'd0;
    end else begin
      sync1_r <= btn_raw;
      sync2_r <= sync1_r;
    end
  end

  // Per-bit debounce: stable flips only after DEBOUNCE_CYCLES consecutive differing samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stable_r      <= 4'd0;
      stable_prev_r <= 4'd0;
      for (int i = 0; i < 4; i++) begin
        db_cnt_r[i] <= '0;
      end
    end else begin
      stable_prev_r <= stable_r;
      for (int i = 0; i < 4; i++) begin
        if (sync2_r[i] == stable_r[i]) begin
          db_cnt_r[i] <= '0;
        end else if (db_cnt_r[i] == DB_MAX) begin
          stable_r[i] <= sync2_r[i];
          db_cnt_r[i] <= '0;
        end else begin
          db_cnt_r[i] <= db_cnt_r[i] + CW'(1);
        end
      end
    end
  end

  assign press_s     = stable_r & ~stable_prev_r;
  assign held_mask_s = 4'b0001 << move_dir_r;

  // Next-state: resolve accept/release first, then let a press event load a new move.
  always_comb begin
    valid_s = move_valid_r;
    dir_s   = move_dir_r;
    mid_s   = state_r;
    state_s = state_r;
    case (state_r)
      ST_PENDING: begin
        if (move_ready) begin
          valid_s = 1'b0;
          mid_s   = stable_r[move_dir_r] ? ST_HELD : ST_IDLE;
        end else begin
          mid_s = ST_PENDING;
        end
      end
      ST_HELD: begin
        if (!stable_r[move_dir_r]) begin
          mid_s = ST_IDLE;
        end else begin
          mid_s = ST_HELD;
        end
      end
      default: mid_s = ST_IDLE;
    endcase
    // The held button itself cannot start a fresh move while still held.
    evt_s  = (mid_s == ST_HELD) ? (press_s & ~held_mask_s) : press_s;
    take_s = (mid_s != ST_PENDING) && (evt_s != 4'd0);
    if (take_s) begin
      state_s = ST_PENDING;
      valid_s = 1'b1;
      dir_s   = pick_dir(evt_s);
    end else begin
      state_s = mid_s;
    end
`ifdef BTN_AUTOREPEAT_EN
    rep_cnt_s  = rep_cnt_r;
    rep_flag_s = rep_flag_r;
    if (take_s) begin
      rep_flag_s = 1'b0;
    end else if ((state_r == ST_PENDING) && (mid_s == ST_HELD)) begin
      rep_cnt_s = rep_flag_r ? RW'(REPEAT_RATE_FRAMES) : RW'(REPEAT_DELAY_FRAMES);
    end else if ((state_r == ST_HELD) && (mid_s == ST_HELD) && frame_tick) begin
      if (rep_cnt_r <= RW'(1)) begin
        rep_cnt_s  = '0;
        rep_flag_s = 1'b1;
        valid_s    = 1'b1;
        state_s    = ST_PENDING;
      end else begin
        rep_cnt_s = rep_cnt_r - RW'(1);
      end
    end else if (mid_s == ST_IDLE) begin
      rep_cnt_s = '0;
    end else begin
      rep_cnt_s = rep_cnt_r;
    end
`endif
  end

  // FSM and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      move_valid_r <= 1'b0;
      move_dir_r   <= 2'd0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_r    <= '0;
      rep_flag_r   <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      move_valid_r <= valid_s;
      move_dir_r   <= dir_s;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt_r    <= rep_cnt_s;
      rep_flag_r   <= rep_flag_s;
`endif
    end
  end

  assign move_valid  = move_valid_r;
  assign move_dir    = move_dir_r;
  assign btn_stable  = stable_r;
  assign any_pressed = |stable_r;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4 (auto-repeat scenario when BTN_AUTOREPEAT_EN is defined).
module tb_button_conditioner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic       frame_tick;
  logic       move_ready;
  logic       move_valid;
  logic [1:0] move_dir;
  logic [3:0] btn_stable;
  logic       any_pressed;

  int   vectors = 0;
  int   miscompares = 0;
  int   rises = 0;
  int   r0;
  logic mv_prev = 1'b0;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY_FRAMES(3),
    .REPEAT_RATE_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .btn_raw(btn_raw),
    .frame_tick(frame_tick),
    .move_ready(move_ready),
    .move_valid(move_valid),
    .move_dir(move_dir),
    .btn_stable(btn_stable),
    .any_pressed(any_pressed)
  );

  always #5 clk = ~clk;

  // Counts rising edges of move_valid to detect extra moves.
  always @(posedge clk) begin
    if (move_valid && !mv_prev) rises <= rises + 1;
    mv_prev <= move_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn_raw = 4'hF; move_ready = 1'b0; frame_tick = 1'b0;
    step(3);
    vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b want 0", move_valid); end
    vectors++; if (move_dir !== 2'd0) begin miscompares++; $display("FAIL rst_dir got %0d want 0", move_dir); end
    vectors++; if (btn_stable !== 4'h0) begin miscompares++; $display("FAIL rst_stable got %h want 0", btn_stable); end
    vectors++; if (any_pressed !== 1'b0) begin miscompares++; $display("FAIL rst_any got %0b want 0", any_pressed); end
    rst_n = 1'b1;
    step(5);
    vectors++; if (btn_stable !== 4'h0) begin miscompares++; $display("FAIL rst_stable_e5 got %h want 0", btn_stable); end
    step(1);
    vectors++; if (btn_stable !== 4'hF) begin miscompares++; $display("FAIL rst_stable_e6 got %h want f", btn_stable); end
    vectors++; if (any_pressed !== 1'b1) begin miscompares++; $display("FAIL rst_any_e6 got %0b want 1", any_pressed); end
    vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid_e6 got %0b want 0", move_valid); end
    step(1);
    vectors++; if ({move_valid, move_dir} !== 3'b100) begin miscompares++; $display("FAIL rst_move_e7 got v%0b d%0d want v1 d0", move_valid, move_dir); end
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL rst_accept got %0b want 0", move_valid); end
    btn_raw = 4'h0;
    step(8);
    vectors++; if ({move_valid, btn_stable} !== 5'b0) begin miscompares++; $display("FAIL rst_release got v%0b s%h want v0 s0", move_valid, btn_stable); end
  endtask

  task automatic test_press_hold;
    btn_raw = 4'h8;
    step(7);
    vectors++; if ({move_valid, move_dir} !== 3'b111) begin miscompares++; $display("FAIL right_move got v%0b d%0d want v1 d3", move_valid, move_dir); end
    step(20);
    vectors++; if ({move_valid, move_dir} !== 3'b111) begin miscompares++; $display("FAIL right_hold got v%0b d%0d want v1 d3", move_valid, move_dir); end
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL right_accept got %0b want 0", move_valid); end
    r0 = rises;
    step(20);
    vectors++; if (move_valid !== 1'b0 || rises != r0) begin miscompares++; $display("FAIL right_norepeat got v%0b rises%0d want v0 rises%0d", move_valid, rises, r0); end
    btn_raw = 4'h0;
    step(8);
  endtask

  task automatic test_bounce;
    r0 = rises;
    for (int k = 0; k < 10; k++) begin
      btn_raw[3] = ~btn_raw[3];
      step(2);
    end
    vectors++; if (btn_stable[3] !== 1'b0) begin miscompares++; $display("FAIL bounce_stable got %0b want 0", btn_stable[3]); end
    btn_raw = 4'h8;
    step(5);
    vectors++; if (btn_stable[3] !== 1'b0) begin miscompares++; $display("FAIL bounce_early got %0b want 0", btn_stable[3]); end
    step(1);
    vectors++; if (btn_stable[3] !== 1'b1) begin miscompares++; $display("FAIL bounce_e6 got %0b want 1", btn_stable[3]); end
    step(1);
    vectors++; if ({move_valid, move_dir} !== 3'b111) begin miscompares++; $display("FAIL bounce_move got v%0b d%0d want v1 d3", move_valid, move_dir); end
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    step(10);
    vectors++; if (rises - r0 != 1) begin miscompares++; $display("FAIL bounce_count got %0d want 1", rises - r0); end
    btn_raw = 4'h0;
    step(8);
  endtask

  task automatic test_simultaneous;
    btn_raw = 4'b0110;
    step(7);
    vectors++; if ({move_valid, move_dir} !== 3'b101) begin miscompares++; $display("FAIL simul_move got v%0b d%0d want v1 d1", move_valid, move_dir); end
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    btn_raw = 4'b0010;
    step(8);
    vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL simul_single got %0b want 0", move_valid); end
    btn_raw = 4'b0110;
    step(7);
    vectors++; if ({move_valid, move_dir} !== 3'b110) begin miscompares++; $display("FAIL simul_repress got v%0b d%0d want v1 d2", move_valid, move_dir); end
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL simul_accept got %0b want 0", move_valid); end
    btn_raw = 4'h0;
    step(8);
  endtask

  task automatic test_drop_pending;
    btn_raw = 4'b1000;
    step(7);
    btn_raw = 4'b1001;
    step(10);
    vectors++; if ({move_valid, move_dir} !== 3'b111) begin miscompares++; $display("FAIL drop_frozen got v%0b d%0d want v1 d3", move_valid, move_dir); end
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    step(10);
    vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL drop_noup got %0b want 0", move_valid); end
    btn_raw = 4'h0;
    step(8);
  endtask

  task automatic test_back_to_back;
    btn_raw = 4'b0010;
    step(7);
    vectors++; if ({move_valid, move_dir} !== 3'b101) begin miscompares++; $display("FAIL b2b_first got v%0b d%0d want v1 d1", move_valid, move_dir); end
    btn_raw = 4'b0110;
    step(6);
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    vectors++; if ({move_valid, move_dir} !== 3'b110) begin miscompares++; $display("FAIL b2b_second got v%0b d%0d want v1 d2", move_valid, move_dir); end
    move_ready = 1'b1;
    step(1);
    move_ready = 1'b0;
    vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_accept got %0b want 0", move_valid); end
    btn_raw = 4'h0;
    step(8);
  endtask

  task automatic test_reset_pending;
    btn_raw = 4'b0001;
    step(7);
    vectors++; if ({move_valid, move_dir} !== 3'b100) begin miscompares++; $display("FAIL rstp_move got v%0b d%0d want v1 d0", move_valid, move_dir); end
    rst_n = 1'b0;
    step(1);
    vectors++; if ({move_valid, btn_stable} !== 5'b0) begin miscompares++; $display("FAIL rstp_clear got v%0b s%h want v0 s0", move_valid, btn_stable); end
    btn_raw = 4'h0;
    rst_n = 1'b1;
    step(8);
    vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL rstp_lost got %0b want 0", move_valid); end
  endtask

`ifdef BTN_AUTOREPEAT_EN
  task automatic test_autorepeat;
    logic exp_v;
    move_ready = 1'b1;
    btn_raw = 4'b0100;
    step(7);
    vectors++; if ({move_valid, move_dir} !== 3'b110) begin miscompares++; $display("FAIL rep_initial got v%0b d%0d want v1 d2", move_valid, move_dir); end
    step(3);
    for (int k = 1; k <= 7; k++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      exp_v = (k == 3 || k == 5 || k == 7) ? 1'b1 : 1'b0;
      vectors++; if (move_valid !== exp_v || move_dir !== 2'd2) begin miscompares++; $display("FAIL rep_tick%0d got v%0b d%0d want v%0b d2", k, move_valid, move_dir, exp_v); end
      step(3);
    end
    btn_raw = 4'h0;
    step(8);
    for (int k = 0; k < 4; k++) begin
      frame_tick = 1'b1;
      step(1);
      frame_tick = 1'b0;
      vectors++; if (move_valid !== 1'b0) begin miscompares++; $display("FAIL rep_stopped got %0b want 0", move_valid); end
      step(2);
    end
    move_ready = 1'b0;
  endtask
`endif

  initial begin
    test_reset;
    test_press_hold;
    test_bounce;
    test_simultaneous;
    test_drop_pending;
    test_back_to_back;
    test_reset_pending;
`ifdef BTN_AUTOREPEAT_EN
    test_autorepeat;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
